hex_entry: RTL and testbench

HEX_ENTRY -- requirements
Module: hex_entry

---
 rtl/aes_io_pkg.sv | 13 +
 rtl/btn_debounce.sv | 53 +++++
 rtl/hex_entry.sv | 87 ++++++++
 tb/tb_hex_entry.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_io_pkg.sv
// Shared types and sizes for the hex nibble entry front end.
package aes_io_pkg;

  localparam int unsigned NIBBLES = 32;
  localparam int unsigned DATA_W  = 128;

  typedef enum logic [1:0] {
    ENTRY = 2'd0,
    FULL  = 2'd1,
    OFFER = 2'd2
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Raw pushbutton -> 2-flop synchronizer -> debouncer -> single-cycle press pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic clr_n,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic          s1, s2;
  logic          acc;
  logic [CW-1:0] cnt;
  logic [1:0]    settle;
  logic          armed;
  logic          flip;

  assign flip = (s2 != acc) && (cnt == CW'(DEBOUNCE_CYCLES - 1));

  // Synchronizer, debounce counter and accepted state.
  // A press is only reported once the button has been seen released after
  // reset (settle covers the synchronizer refill), so a button held through
  // reset release gives no pulse until it is released and pressed again.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      acc    <= 1'b0;
      cnt    <= '0;
      settle <= '0;
      armed  <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      s1     <= btn;
      s2     <= s1;
      settle <= {settle[0], 1'b1};
      if (settle[1] && !s2 && !acc)
        armed <= 1'b1;
      pulse <= flip && !acc && armed;
      if (s2 == acc) begin
        cnt <= '0;
      end else if (flip) begin
        acc <= ~acc;
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/hex_entry.sv
// Hex nibble entry: builds a 128-bit value from switch nibbles via debounced
// enter/back/commit buttons and offers it over a valid/ready handshake.
module hex_entry
  import aes_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [3:0]        sw,
  input  logic              btn_enter,
  input  logic              btn_back,
  input  logic              btn_commit,
  output logic [0:DATA_W-1] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [5:0]        o_idx,
  output logic [0:15]       o_window
);

  state_t     state;
  logic       p_enter, p_back, p_commit;
  logic [5:0] idx_m1;
  logic [4:0] win_nib;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
    .clk(clk), .clr_n(clr_n), .btn(btn_enter), .pulse(p_enter)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back (
    .clk(clk), .clr_n(clr_n), .btn(btn_back), .pulse(p_back)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_commit (
    .clk(clk), .clr_n(clr_n), .btn(btn_commit), .pulse(p_commit)
  );

  assign idx_m1 = o_idx - 6'd1;

  // Display window: the 16-bit group holding nibble min(o_idx, 31).
  always_comb begin
    win_nib  = o_idx[5] ? 5'd31 : o_idx[4:0];
    o_window = o_data[{win_nib[4:2], 4'b0000} +: 16];
  end

  // Entry FSM; commit > back > enter, lower-priority pulses are dropped.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= ENTRY;
      o_data  <= '0;
      o_idx   <= '0;
      o_valid <= 1'b0;
    end else begin
      case (state)
        ENTRY: begin
          if (p_back && (o_idx != '0)) begin
            o_idx                            <= idx_m1;
            o_data[{idx_m1[4:0], 2'b00} +: 4] <= '0;
          end else if (p_enter) begin
            o_data[{o_idx[4:0], 2'b00} +: 4] <= sw;
            o_idx                            <= o_idx + 6'd1;
            if (o_idx == 6'(NIBBLES - 1))
              state <= FULL;
          end
        end
        FULL: begin
          if (p_commit) begin
            state   <= OFFER;
            o_valid <= 1'b1;
          end else if (p_back) begin
            o_idx                            <= idx_m1;
            o_data[{idx_m1[4:0], 2'b00} +: 4] <= '0;
            state                            <= ENTRY;
          end
        end
        OFFER: begin
          if (i_ready) begin
            state   <= ENTRY;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_idx   <= '0;
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_hex_entry.sv
// Self-checking bench for hex_entry with a short debounce period.
module tb_hex_entry;

  localparam int unsigned DB = 4;

  logic         clk = 1'b0;
  logic         clr_n;
  logic [3:0]   sw;
  logic         btn_enter, btn_back, btn_commit;
  logic [0:127] o_data;
  logic         o_valid;
  logic         i_ready;
  logic [5:0]   o_idx;
  logic [0:15]  o_window;

  logic [127:0] dat;
  logic [15:0]  win;
  assign dat = o_data;
  assign win = o_window;

  hex_entry #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .clr_n(clr_n), .sw(sw),
    .btn_enter(btn_enter), .btn_back(btn_back), .btn_commit(btn_commit),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_idx(o_idx), .o_window(o_window)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string        name;
    logic [5:0]   idx;
    logic         valid;
    logic [127:0] data;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [2:0]   m;     // {commit, back, enter}
    logic [3:0]   sw;
    logic [5:0]   idx;
    logic [127:0] data;
  } vec_t;

  vec_t tbl[10];

  localparam logic [127:0] FULL_VAL = 128'h0123456789ABCDEF0123456789ABCDEF;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input logic [5:0] idx, input logic v, input logic [127:0] d);
    exp_t e;
    e.name = nm; e.idx = idx; e.valid = v; e.data = d;
    sb.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: got empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      chk({e.name, " idx"},   128'(o_idx),   128'(e.idx));
      chk({e.name, " valid"}, 128'(o_valid), 128'(e.valid));
      chk({e.name, " data"},  dat,           e.data);
    end
  endtask

  // Drive a button combination (all raw edges aligned), hold, release, settle.
  task automatic press(input logic [2:0] m, input int hold);
    @(negedge clk);
    {btn_commit, btn_back, btn_enter} = m;
    repeat (hold) @(negedge clk);
    {btn_commit, btn_back, btn_enter} = 3'b000;
    repeat (12) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic fill32();
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      sw = 4'(i % 16);
      m[127 - 4*i -: 4] = sw;
      push($sformatf("fill%0d", i), 6'(i + 1), 1'b0, m);
      press(3'b001, 10);
      sb_check();
    end
  endtask

  initial begin
    clr_n = 1'b0; i_ready = 1'b0; sw = '0;
    btn_enter = 1'b0; btn_back = 1'b0; btn_commit = 1'b0;

    tbl[0] = '{3'b010, 4'h0, 6'd0, 128'h0};
    tbl[1] = '{3'b001, 4'h1, 6'd1, 128'h1 << 124};
    tbl[2] = '{3'b001, 4'h2, 6'd2, 128'h12 << 120};
    tbl[3] = '{3'b001, 4'h3, 6'd3, 128'h123 << 116};
    tbl[4] = '{3'b010, 4'h0, 6'd2, 128'h12 << 120};
    tbl[5] = '{3'b100, 4'h0, 6'd2, 128'h12 << 120};
    tbl[6] = '{3'b001, 4'h4, 6'd3, 128'h124 << 116};
    tbl[7] = '{3'b001, 4'h5, 6'd4, 128'h1245 << 112};
    tbl[8] = '{3'b001, 4'h6, 6'd5, 128'h12456 << 108};
    tbl[9] = '{3'b011, 4'h7, 6'd4, 128'h1245 << 112};

    // Reset state
    #12;
    chk("reset idx",    128'(o_idx),   128'd0);
    chk("reset valid",  128'(o_valid), 128'd0);
    chk("reset data",   dat,           128'h0);
    chk("reset window", 128'(win),     128'h0);
    @(negedge clk); clr_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single enter, long hold: exactly one write
    sw = 4'hA;
    push("enterA", 6'd1, 1'b0, 128'hA << 124);
    press(3'b001, 20);
    sb_check();
    chk("enterA window", 128'(win), 128'hA000);

    // Table-driven back/enter/commit sequence from a fresh start
    do_reset();
    for (int i = 0; i < 10; i++) begin
      sw = tbl[i].sw;
      push($sformatf("vec%0d", i), tbl[i].idx, 1'b0, tbl[i].data);
      press(tbl[i].m, 10);
      sb_check();
    end

    // Full 32-nibble entry, FULL behaviour, offer and handshake
    do_reset();
    fill32();
    chk("full value", dat, FULL_VAL);
    chk("full window", 128'(win), 128'hCDEF);
    sw = 4'h3;
    push("enter in FULL", 6'd32, 1'b0, FULL_VAL);
    press(3'b001, 10);
    sb_check();
    push("back in FULL", 6'd31, 1'b0, FULL_VAL & ~128'hF);
    press(3'b010, 10);
    sb_check();
    sw = 4'hF;
    push("refill 32", 6'd32, 1'b0, FULL_VAL);
    press(3'b001, 10);
    sb_check();
    push("commit+back", 6'd32, 1'b1, FULL_VAL);
    press(3'b110, 10);
    sb_check();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("hold valid c%0d", c), 128'(o_valid), 128'd1);
      chk($sformatf("hold data c%0d", c),  dat,           FULL_VAL);
    end
    push("enter in OFFER", 6'd32, 1'b1, FULL_VAL);
    press(3'b011, 10);
    sb_check();
    @(negedge clk); i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    push("handshake", 6'd0, 1'b0, 128'h0);
    sb_check();

    // Bounce glitches shorter than the debounce period are rejected
    for (int g = 0; g < 3; g++) begin
      @(negedge clk); btn_enter = 1'b1;
      repeat (3) @(negedge clk);
      btn_enter = 1'b0;
      repeat (8) @(negedge clk);
    end
    push("glitch", 6'd0, 1'b0, 128'h0);
    sb_check();

    // Asynchronous reset during OFFER, with enter held across release
    fill32();
    push("commit", 6'd32, 1'b1, FULL_VAL);
    press(3'b100, 10);
    sb_check();
    @(negedge clk); btn_enter = 1'b1; sw = 4'h9;
    repeat (10) @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("async rst valid", 128'(o_valid), 128'd0);
    chk("async rst idx",   128'(o_idx),   128'd0);
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("held thru reset idx", 128'(o_idx), 128'd0);
    btn_enter = 1'b0;
    repeat (12) @(negedge clk);
    chk("released idx", 128'(o_idx), 128'd0);
    push("repress", 6'd1, 1'b0, 128'h9 << 124);
    press(3'b001, 10);
    sb_check();

    chk("scoreboard drained", 128'(sb.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule
